// File: rtl/audio_tx_stereo.sv
// ---------------------------------------------------------------------------
// audio_tx_stereo
//
// I2S-style stereo transmitter with a small frame FIFO. A producer pushes
// whole stereo frames ({left, right}). At every left-slot start (falling
// LRC) one frame is moved into the hold registers and serialised MSB first
// on the falling edge of the bit clock, one bit after the LRC transition.
// Zeros are sent when playback is disabled or when the FIFO has run dry.
//
// Parameters
//   DATA_W      sample width per channel (16..32)
//   SLOT_W      bit clocks per LRC half-period (DATA_W..63)
//   FIFO_DEPTH  stereo frames buffered (power of two, >= 2)
//
// Ports
//   rst_n        in   asynchronous active-low reset
//   aud_bclk     in   bit clock (state on posedge, aud_dacdat on negedge)
//   aud_lrc      in   word select, 0 = left slot, 1 = right slot
//   play_enable  in   playback enable, looked at only at frame start
//   wr_valid     in   push request for one stereo frame
//   wr_ready     out  FIFO not full
//   wr_left      in   left sample to push
//   wr_right     in   right sample to push
//   aud_dacdat   out  serial data, MSB first
//   fifo_level   out  number of frames stored
//   frame_done   out  one-cycle pulse once the right-channel data bits are out
//   underrun     out  one-cycle pulse when a frame starts on an empty FIFO
// ---------------------------------------------------------------------------
module audio_tx_stereo #(
  parameter int DATA_W     = 24,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             rst_n,
  input  logic                             aud_bclk,
  input  logic                             aud_lrc,
  input  logic                             play_enable,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [DATA_W-1:0]                wr_left,
  input  logic [DATA_W-1:0]                wr_right,
  output logic                             aud_dacdat,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             frame_done,
  output logic                             underrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [5:0]        DATA_W6  = 6'(DATA_W);
  localparam logic [5:0]        SLOT_W6  = 6'(SLOT_W);
  localparam logic [LVL_W-1:0]  DEPTH_L  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [DATA_W-1:0] ONE_DW   = DATA_W'(1);

  logic                lrcD0_q;
  logic                lrcEdge;
  logic                frameStart;

  logic [2*DATA_W-1:0] fifoMem_q [FIFO_DEPTH];
  logic [2*DATA_W-1:0] popWord;
  logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                fifoEmpty;
  logic                fifoFull;
  logic                push;
  logic                pop;

  logic [DATA_W-1:0]   holdLeft_q, holdLeft_d;
  logic [DATA_W-1:0]   holdRight_q, holdRight_d;
  logic                underrun_q, underrun_d;

  logic [5:0]          bitCnt_q, bitCnt_d;
  logic                doneSeen_q, doneSeen_d;
  logic                frameDone_q, frameDone_d;
  logic                doneFire;

  logic [DATA_W-1:0]   curWord;
  logic [DATA_W-1:0]   bitMask;
  logic [5:0]          bitIdx;
  logic                dacBit;
  logic                dacdat_q;

  // LRC edge detection and FIFO handshake. A frame starts on the posedge
  // that first sees LRC low after it was high. Pop only happens at a frame
  // start with playback enabled and something stored; a push in the same
  // cycle never counts towards that decision, so pushing into an empty FIFO
  // at frame start still underruns.
  always_comb begin
    lrcEdge    = aud_lrc ^ lrcD0_q;
    frameStart = lrcEdge & ~aud_lrc;
    fifoEmpty  = (level_q == '0);
    fifoFull   = (level_q == DEPTH_L);
    wr_ready   = ~fifoFull;
    push       = wr_valid & ~fifoFull;
    pop        = frameStart & play_enable & ~fifoEmpty;
  end

  // Pointer and level bookkeeping. Pointers wrap naturally because the
  // depth is a power of two; a simultaneous push and pop leaves the level
  // where it was.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end
    if (push && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (pop && !push) begin
      level_d = level_q - LVL_ONE;
    end
  end

  // Hold register reload at frame start. Anything other than a real pop
  // (muted or starved) loads silence; only the starved case flags underrun.
  always_comb begin
    holdLeft_d  = holdLeft_q;
    holdRight_d = holdRight_q;
    underrun_d  = 1'b0;
    popWord     = fifoMem_q[rdPtr_q];
    if (frameStart) begin
      if (pop) begin
        holdLeft_d  = popWord[2*DATA_W-1:DATA_W];
        holdRight_d = popWord[DATA_W-1:0];
      end else begin
        holdLeft_d  = '0;
        holdRight_d = '0;
        underrun_d  = play_enable;
      end
    end
  end

  // Slot bit counter and end-of-frame detection. The counter restarts on
  // every LRC edge, so an early toggle simply abandons the rest of the old
  // slot. doneSeen keeps frame_done to one pulse even when the counter
  // saturates right at DATA_W (SLOT_W == DATA_W).
  always_comb begin
    bitCnt_d = bitCnt_q;
    if (lrcEdge) begin
      bitCnt_d = '0;
    end else if (bitCnt_q < SLOT_W6) begin
      bitCnt_d = bitCnt_q + 6'd1;
    end
    doneFire    = lrcD0_q & (bitCnt_q == DATA_W6) & ~doneSeen_q;
    frameDone_d = doneFire;
    doneSeen_d  = lrcEdge ? 1'b0 : (doneSeen_q | doneFire);
  end

  // Bit selection for the serialiser: the channel is the registered LRC,
  // and bits past the sample width are padded with zeros.
  always_comb begin
    curWord = lrcD0_q ? holdRight_q : holdLeft_q;
    bitIdx  = DATA_W6 - 6'd1 - bitCnt_q;
    bitMask = ONE_DW << bitIdx;
    dacBit  = (bitCnt_q < DATA_W6) ? |(curWord & bitMask) : 1'b0;
  end

  // Frame storage. Contents carry no reset; the level counter guarantees
  // that only written entries are ever read.
  always_ff @(posedge aud_bclk) begin
    if (push) begin
      fifoMem_q[wrPtr_q] <= {wr_left, wr_right};
    end
  end

  // All posedge state of the transmitter.
  always_ff @(posedge aud_bclk or negedge rst_n) begin
    if (!rst_n) begin
      lrcD0_q     <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      holdLeft_q  <= '0;
      holdRight_q <= '0;
      underrun_q  <= 1'b0;
      bitCnt_q    <= '0;
      doneSeen_q  <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      lrcD0_q     <= aud_lrc;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      level_q     <= level_d;
      holdLeft_q  <= holdLeft_d;
      holdRight_q <= holdRight_d;
      underrun_q  <= underrun_d;
      bitCnt_q    <= bitCnt_d;
      doneSeen_q  <= doneSeen_d;
      frameDone_q <= frameDone_d;
    end
  end

  // Serial data changes on the falling edge so the receiver can sample it
  // on the rising edge. Launching from the bit selected after the
  // edge-detect posedge gives the I2S one-bit delay.
  always_ff @(negedge aud_bclk or negedge rst_n) begin
    if (!rst_n) begin
      dacdat_q <= 1'b0;
    end else begin
      dacdat_q <= dacBit;
    end
  end

  assign aud_dacdat = dacdat_q;
  assign fifo_level = level_q;
  assign frame_done = frameDone_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_audio_tx_stereo.sv
// ---------------------------------------------------------------------------
// tb_audio_tx_stereo
//
// Self-checking bench for audio_tx_stereo (DATA_W=24, SLOT_W=32,
// FIFO_DEPTH=4). The bench drives LRC slot by slot, captures the serial
// stream of each slot into a word (MSB first) and compares it with a
// frame-level reference: a queue of pushed frames from which each frame
// start pops one frame, or yields silence when muted or starved.
// Inputs change #1 after a falling edge; registered outputs are sampled
// #1 after a rising edge, aud_dacdat #1 after a falling edge.
// ---------------------------------------------------------------------------
module tb_audio_tx_stereo;

  localparam int DATA_W     = 24;
  localparam int SLOT_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

  logic              rst_n;
  logic              aud_bclk;
  logic              aud_lrc;
  logic              play_enable;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_left;
  logic [DATA_W-1:0] wr_right;
  logic              aud_dacdat;
  logic [LVL_W-1:0]  fifo_level;
  logic              frame_done;
  logic              underrun;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [2*DATA_W-1:0] modelQ [$];

  audio_tx_stereo #(
    .DATA_W    (DATA_W),
    .SLOT_W    (SLOT_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .rst_n      (rst_n),
    .aud_bclk   (aud_bclk),
    .aud_lrc    (aud_lrc),
    .play_enable(play_enable),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_left    (wr_left),
    .wr_right   (wr_right),
    .aud_dacdat (aud_dacdat),
    .fifo_level (fifo_level),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  // Free-running bit clock, 10 time units per period.
  initial begin
    aud_bclk = 1'b0;
    forever #5 aud_bclk = ~aud_bclk;
  end

  // Move to the standard drive point: just after the next falling edge.
  task automatic toNeg();
    @(negedge aud_bclk);
    #1;
  endtask

  // Expected serial word of one slot: sample MSB first, zero padded.
  function automatic logic [SLOT_W-1:0] slotWord(input logic [DATA_W-1:0] s);
    logic [SLOT_W-1:0] w;
    w = '0;
    w[SLOT_W-1 -: DATA_W] = s;
    return w;
  endfunction

  // Push one frame in a single cycle with LRC left untouched; the
  // reference accepts it only when fewer than FIFO_DEPTH frames are held.
  task automatic applyStimulus(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    wr_valid = 1'b1;
    wr_left  = l;
    wr_right = r;
    @(posedge aud_bclk);
    #1;
    wr_valid = 1'b0;
    if (modelQ.size() < FIFO_DEPTH) modelQ.push_back({l, r});
    toNeg();
  endtask

  // Reference decision at a frame start: pop if enabled and non-empty,
  // otherwise silence (underrun only when enabled). A push in the same
  // cycle is stored afterwards if the FIFO was not already full.
  task automatic modelStart(input logic pe, input logic doPush,
                            input logic [DATA_W-1:0] pl, input logic [DATA_W-1:0] pr,
                            output logic [DATA_W-1:0] expL, output logic [DATA_W-1:0] expR,
                            output int expUr);
    logic [2*DATA_W-1:0] f;
    logic wasFull;
    wasFull = (modelQ.size() >= FIFO_DEPTH);
    expL = '0;
    expR = '0;
    expUr = 0;
    if (pe) begin
      if (modelQ.size() > 0) begin
        f = modelQ.pop_front();
        expL = f[2*DATA_W-1:DATA_W];
        expR = f[DATA_W-1:0];
      end else begin
        expUr = 1;
      end
    end
    if (doPush && !wasFull) modelQ.push_back({pl, pr});
  endtask

  // Drive one LRC slot of len bit clocks and capture what comes out:
  // serial bits (MSB first), frame_done and underrun pulse counts with the
  // slot cycle of their first appearance. Optionally pushes a frame in the
  // first cycle and changes play_enable after cycle peAt.
  task automatic runSlot(input logic lrcVal, input int len, input logic doPush,
                         input logic [DATA_W-1:0] pl, input logic [DATA_W-1:0] pr,
                         input int peAt, input logic peNew,
                         output logic [SLOT_W-1:0] bits,
                         output int fdCount, output int fdPos,
                         output int urCount, output int urPos);
    bits = '0;
    fdCount = 0;
    fdPos = -1;
    urCount = 0;
    urPos = -1;
    aud_lrc = lrcVal;
    if (doPush) begin
      wr_valid = 1'b1;
      wr_left  = pl;
      wr_right = pr;
    end
    for (int j = 0; j < len; j++) begin
      @(posedge aud_bclk);
      #1;
      wr_valid = 1'b0;
      if (frame_done === 1'b1) begin
        fdCount++;
        if (fdPos < 0) fdPos = j;
      end
      if (underrun === 1'b1) begin
        urCount++;
        if (urPos < 0) urPos = j;
      end
      if (j == peAt) play_enable = peNew;
      @(negedge aud_bclk);
      #1;
      if (j < SLOT_W) bits[SLOT_W-1-j] = aud_dacdat;
    end
  endtask

  // Reset values while rst_n is low, then release with LRC high: the
  // first slot is a right slot and must be silent.
  task automatic test_reset();
    logic [SLOT_W-1:0] bits;
    int fdC, fdP, urC, urP;
    rst_n = 1'b0;
    aud_lrc = 1'b1;
    play_enable = 1'b0;
    wr_valid = 1'b0;
    wr_left = '0;
    wr_right = '0;
    repeat (3) toNeg();
    testsRun++;
    if (aud_dacdat !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_dacdat: got %b, expected 0", aud_dacdat); end
    testsRun++;
    if (underrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_underrun: got %b, expected 0", underrun); end
    testsRun++;
    if (frame_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_frame_done: got %b, expected 0", frame_done); end
    testsRun++;
    if (fifo_level !== '0) begin testsFailed++; $display("[TB] FAIL reset_level: got %0d, expected 0", fifo_level); end
    testsRun++;
    if (wr_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_wr_ready: got %b, expected 1", wr_ready); end
    rst_n = 1'b1;
    modelQ.delete();
    runSlot(1'b1, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bits, fdC, fdP, urC, urP);
    testsRun++;
    if (bits !== '0) begin testsFailed++; $display("[TB] FAIL reset_first_right_slot: got %h, expected 0", bits); end
    testsRun++;
    if (urC != 0) begin testsFailed++; $display("[TB] FAIL reset_no_underrun: got %0d pulses, expected 0", urC); end
  endtask

  // One known frame: fixed bit patterns on both slots, one frame_done
  // right after the last right data bit, level 1 then 0.
  task automatic test_basic();
    logic [SLOT_W-1:0] bitsL, bitsR;
    logic [DATA_W-1:0] expL, expR;
    int expUr, fdC, fdP, urC, urP;
    play_enable = 1'b1;
    applyStimulus(24'hA5A5A5, 24'h5A5A5A);
    testsRun++;
    if (fifo_level !== LVL_W'(1)) begin testsFailed++; $display("[TB] FAIL basic_level_after_push: got %0d, expected 1", fifo_level); end
    modelStart(play_enable, 1'b0, '0, '0, expL, expR, expUr);
    runSlot(1'b0, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsL, fdC, fdP, urC, urP);
    testsRun++;
    if (bitsL !== 32'hA5A5A500) begin testsFailed++; $display("[TB] FAIL basic_left_bits: got %h, expected a5a5a500", bitsL); end
    testsRun++;
    if (fifo_level !== '0) begin testsFailed++; $display("[TB] FAIL basic_level_after_pop: got %0d, expected 0", fifo_level); end
    testsRun++;
    if (urC != 0) begin testsFailed++; $display("[TB] FAIL basic_underrun: got %0d pulses, expected 0", urC); end
    runSlot(1'b1, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsR, fdC, fdP, urC, urP);
    testsRun++;
    if (bitsR !== 32'h5A5A5A00) begin testsFailed++; $display("[TB] FAIL basic_right_bits: got %h, expected 5a5a5a00", bitsR); end
    testsRun++;
    if (fdC != 1 || fdP != DATA_W + 1) begin testsFailed++; $display("[TB] FAIL basic_frame_done: got %0d pulses at %0d, expected 1 at %0d", fdC, fdP, DATA_W + 1); end
  endtask

  // Frame start on an empty FIFO with playback enabled.
  task automatic test_underrun();
    logic [SLOT_W-1:0] bitsL, bitsR;
    logic [DATA_W-1:0] expL, expR;
    int expUr, fdC, fdP, urC, urP, urC2, urP2;
    play_enable = 1'b1;
    modelStart(play_enable, 1'b0, '0, '0, expL, expR, expUr);
    runSlot(1'b0, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsL, fdC, fdP, urC, urP);
    runSlot(1'b1, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsR, fdC, fdP, urC2, urP2);
    testsRun++;
    if (urC != expUr || urP != 0 || urC2 != 0) begin testsFailed++; $display("[TB] FAIL underrun_pulse: got %0d+%0d pulses at %0d, expected %0d at 0", urC, urC2, urP, expUr); end
    testsRun++;
    if (bitsL !== '0 || bitsR !== '0) begin testsFailed++; $display("[TB] FAIL underrun_silence: got %h/%h, expected 0/0", bitsL, bitsR); end
    testsRun++;
    if (fdC != 1) begin testsFailed++; $display("[TB] FAIL underrun_frame_done: got %0d pulses, expected 1", fdC); end
  endtask

  // Five pushes with no frame start: the fifth is refused, then the four
  // stored frames drain in push order.
  task automatic test_full();
    logic [SLOT_W-1:0] bitsL, bitsR;
    logic [DATA_W-1:0] expL, expR;
    int expUr, fdC, fdP, urC, urP;
    play_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(DATA_W'($urandom), DATA_W'($urandom));
      testsRun++;
      if (wr_ready !== (i < FIFO_DEPTH - 1)) begin testsFailed++; $display("[TB] FAIL full_wr_ready_%0d: got %b, expected %b", i, wr_ready, (i < FIFO_DEPTH - 1)); end
    end
    testsRun++;
    if (fifo_level !== LVL_W'(FIFO_DEPTH)) begin testsFailed++; $display("[TB] FAIL full_level: got %0d, expected %0d", fifo_level, FIFO_DEPTH); end
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      modelStart(play_enable, 1'b0, '0, '0, expL, expR, expUr);
      runSlot(1'b0, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsL, fdC, fdP, urC, urP);
      runSlot(1'b1, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsR, fdC, fdP, urC, urP);
      testsRun++;
      if (bitsL !== slotWord(expL) || bitsR !== slotWord(expR)) begin testsFailed++; $display("[TB] FAIL full_drain_%0d: got %h/%h, expected %h/%h", k, bitsL, bitsR, slotWord(expL), slotWord(expR)); end
    end
    testsRun++;
    if (fifo_level !== '0) begin testsFailed++; $display("[TB] FAIL full_drained_level: got %0d, expected 0", fifo_level); end
  endtask

  // play_enable drops mid-left-slot: the current frame still plays, the
  // next frame is muted without popping or underrunning.
  task automatic test_pe_drop();
    logic [SLOT_W-1:0] bitsL, bitsR;
    logic [DATA_W-1:0] expL, expR;
    int expUr, fdC, fdP, urC, urP;
    play_enable = 1'b1;
    applyStimulus(DATA_W'($urandom), DATA_W'($urandom));
    applyStimulus(DATA_W'($urandom), DATA_W'($urandom));
    modelStart(play_enable, 1'b0, '0, '0, expL, expR, expUr);
    runSlot(1'b0, SLOT_W, 1'b0, '0, '0, 5, 1'b0, bitsL, fdC, fdP, urC, urP);
    runSlot(1'b1, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsR, fdC, fdP, urC, urP);
    testsRun++;
    if (bitsL !== slotWord(expL) || bitsR !== slotWord(expR)) begin testsFailed++; $display("[TB] FAIL pe_drop_current_frame: got %h/%h, expected %h/%h", bitsL, bitsR, slotWord(expL), slotWord(expR)); end
    modelStart(play_enable, 1'b0, '0, '0, expL, expR, expUr);
    runSlot(1'b0, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsL, fdC, fdP, urC, urP);
    testsRun++;
    if (urC != expUr) begin testsFailed++; $display("[TB] FAIL pe_drop_underrun: got %0d pulses, expected %0d", urC, expUr); end
    runSlot(1'b1, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsR, fdC, fdP, urC, urP);
    testsRun++;
    if (bitsL !== slotWord(expL) || bitsR !== slotWord(expR)) begin testsFailed++; $display("[TB] FAIL pe_drop_muted_frame: got %h/%h, expected %h/%h", bitsL, bitsR, slotWord(expL), slotWord(expR)); end
    testsRun++;
    if (fifo_level !== LVL_W'(modelQ.size())) begin testsFailed++; $display("[TB] FAIL pe_drop_level: got %0d, expected %0d", fifo_level, modelQ.size()); end
    testsRun++;
    if (fdC != 1) begin testsFailed++; $display("[TB] FAIL pe_drop_frame_done: got %0d pulses, expected 1", fdC); end
    play_enable = 1'b1;
    modelStart(play_enable, 1'b0, '0, '0, expL, expR, expUr);
    runSlot(1'b0, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsL, fdC, fdP, urC, urP);
    runSlot(1'b1, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsR, fdC, fdP, urC, urP);
    testsRun++;
    if (bitsL !== slotWord(expL) || bitsR !== slotWord(expR)) begin testsFailed++; $display("[TB] FAIL pe_drop_resume: got %h/%h, expected %h/%h", bitsL, bitsR, slotWord(expL), slotWord(expR)); end
  endtask

  // Push coinciding with a frame start: with one frame stored the older
  // one plays and the level stays 1; into an empty FIFO it underruns but
  // the frame is kept for the next frame.
  task automatic test_back_to_back();
    logic [SLOT_W-1:0] bitsL, bitsR;
    logic [DATA_W-1:0] expL, expR, pl, pr;
    int expUr, fdC, fdP, urC, urP;
    play_enable = 1'b1;
    applyStimulus(DATA_W'($urandom), DATA_W'($urandom));
    pl = DATA_W'($urandom);
    pr = DATA_W'($urandom);
    modelStart(play_enable, 1'b1, pl, pr, expL, expR, expUr);
    runSlot(1'b0, SLOT_W, 1'b1, pl, pr, -1, 1'b0, bitsL, fdC, fdP, urC, urP);
    testsRun++;
    if (fifo_level !== LVL_W'(1)) begin testsFailed++; $display("[TB] FAIL b2b_level_push_pop: got %0d, expected 1", fifo_level); end
    runSlot(1'b1, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsR, fdC, fdP, urC, urP);
    testsRun++;
    if (bitsL !== slotWord(expL) || bitsR !== slotWord(expR)) begin testsFailed++; $display("[TB] FAIL b2b_older_frame: got %h/%h, expected %h/%h", bitsL, bitsR, slotWord(expL), slotWord(expR)); end
    modelStart(play_enable, 1'b0, '0, '0, expL, expR, expUr);
    runSlot(1'b0, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsL, fdC, fdP, urC, urP);
    runSlot(1'b1, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsR, fdC, fdP, urC, urP);
    testsRun++;
    if (bitsL !== slotWord(expL) || bitsR !== slotWord(expR)) begin testsFailed++; $display("[TB] FAIL b2b_newer_frame: got %h/%h, expected %h/%h", bitsL, bitsR, slotWord(expL), slotWord(expR)); end
    pl = DATA_W'($urandom);
    pr = DATA_W'($urandom);
    modelStart(play_enable, 1'b1, pl, pr, expL, expR, expUr);
    runSlot(1'b0, SLOT_W, 1'b1, pl, pr, -1, 1'b0, bitsL, fdC, fdP, urC, urP);
    testsRun++;
    if (urC != expUr || bitsL !== slotWord(expL)) begin testsFailed++; $display("[TB] FAIL b2b_empty_push_underrun: got %0d pulses bits %h, expected %0d bits %h", urC, bitsL, expUr, slotWord(expL)); end
    testsRun++;
    if (fifo_level !== LVL_W'(modelQ.size())) begin testsFailed++; $display("[TB] FAIL b2b_empty_push_stored: got %0d, expected %0d", fifo_level, modelQ.size()); end
    runSlot(1'b1, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsR, fdC, fdP, urC, urP);
    modelStart(play_enable, 1'b0, '0, '0, expL, expR, expUr);
    runSlot(1'b0, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsL, fdC, fdP, urC, urP);
    runSlot(1'b1, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsR, fdC, fdP, urC, urP);
    testsRun++;
    if (bitsL !== slotWord(expL) || bitsR !== slotWord(expR)) begin testsFailed++; $display("[TB] FAIL b2b_stored_frame_plays: got %h/%h, expected %h/%h", bitsL, bitsR, slotWord(expL), slotWord(expR)); end
  endtask

  // Early LRC toggles: a truncated left slot followed by a clean right
  // slot, then a truncated right slot followed by a clean new frame.
  task automatic test_early_toggle();
    logic [SLOT_W-1:0] bitsL, bitsR;
    logic [DATA_W-1:0] expL, expR;
    int expUr, fdC, fdP, urC, urP;
    play_enable = 1'b1;
    applyStimulus(DATA_W'($urandom), DATA_W'($urandom));
    applyStimulus(DATA_W'($urandom), DATA_W'($urandom));
    applyStimulus(DATA_W'($urandom), DATA_W'($urandom));
    modelStart(play_enable, 1'b0, '0, '0, expL, expR, expUr);
    runSlot(1'b0, 10, 1'b0, '0, '0, -1, 1'b0, bitsL, fdC, fdP, urC, urP);
    testsRun++;
    if (bitsL[SLOT_W-1 -: 10] !== expL[DATA_W-1 -: 10]) begin testsFailed++; $display("[TB] FAIL early_left_partial: got %h, expected %h", bitsL[SLOT_W-1 -: 10], expL[DATA_W-1 -: 10]); end
    runSlot(1'b1, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsR, fdC, fdP, urC, urP);
    testsRun++;
    if (bitsR !== slotWord(expR) || fdC != 1 || fdP != DATA_W + 1) begin testsFailed++; $display("[TB] FAIL early_right_after_short_left: got %h fd %0d@%0d, expected %h fd 1@%0d", bitsR, fdC, fdP, slotWord(expR), DATA_W + 1); end
    modelStart(play_enable, 1'b0, '0, '0, expL, expR, expUr);
    runSlot(1'b0, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsL, fdC, fdP, urC, urP);
    runSlot(1'b1, 12, 1'b0, '0, '0, -1, 1'b0, bitsR, fdC, fdP, urC, urP);
    testsRun++;
    if (bitsL !== slotWord(expL) || bitsR[SLOT_W-1 -: 12] !== expR[DATA_W-1 -: 12]) begin testsFailed++; $display("[TB] FAIL early_right_partial: got %h/%h, expected %h/%h", bitsL, bitsR[SLOT_W-1 -: 12], slotWord(expL), expR[DATA_W-1 -: 12]); end
    testsRun++;
    if (fdC != 0) begin testsFailed++; $display("[TB] FAIL early_right_no_done: got %0d pulses, expected 0", fdC); end
    modelStart(play_enable, 1'b0, '0, '0, expL, expR, expUr);
    runSlot(1'b0, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsL, fdC, fdP, urC, urP);
    runSlot(1'b1, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsR, fdC, fdP, urC, urP);
    testsRun++;
    if (bitsL !== slotWord(expL) || bitsR !== slotWord(expR)) begin testsFailed++; $display("[TB] FAIL early_clean_restart: got %h/%h, expected %h/%h", bitsL, bitsR, slotWord(expL), slotWord(expR)); end
  endtask

  // Randomised frames: random push counts, data, enable and push-at-start.
  task automatic test_random();
    logic [SLOT_W-1:0] bitsL, bitsR;
    logic [DATA_W-1:0] expL, expR, pl, pr;
    logic doPush;
    int expUr, fdC, fdP, urC, urP, nPush;
    for (int it = 0; it < 8; it++) begin
      nPush = $urandom_range(0, 2);
      for (int p = 0; p < nPush; p++) applyStimulus(DATA_W'($urandom), DATA_W'($urandom));
      play_enable = ($urandom_range(0, 3) != 0);
      doPush = 1'($urandom_range(0, 1));
      pl = DATA_W'($urandom);
      pr = DATA_W'($urandom);
      modelStart(play_enable, doPush, pl, pr, expL, expR, expUr);
      runSlot(1'b0, SLOT_W, doPush, pl, pr, -1, 1'b0, bitsL, fdC, fdP, urC, urP);
      testsRun++;
      if (urC != expUr) begin testsFailed++; $display("[TB] FAIL random_%0d_underrun: got %0d, expected %0d", it, urC, expUr); end
      runSlot(1'b1, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsR, fdC, fdP, urC, urP);
      testsRun++;
      if (bitsL !== slotWord(expL) || bitsR !== slotWord(expR)) begin testsFailed++; $display("[TB] FAIL random_%0d_data: got %h/%h, expected %h/%h", it, bitsL, bitsR, slotWord(expL), slotWord(expR)); end
      testsRun++;
      if (fifo_level !== LVL_W'(modelQ.size()) || fdC != 1) begin testsFailed++; $display("[TB] FAIL random_%0d_level_done: got level %0d fd %0d, expected %0d fd 1", it, fifo_level, fdC, modelQ.size()); end
    end
  endtask

  // Reset in the middle of a right slot while a 1 is on the line, then
  // silence until data is pushed and a new frame starts.
  task automatic test_reset_mid();
    logic [SLOT_W-1:0] bitsL, bitsR;
    logic [DATA_W-1:0] expL, expR;
    int expUr, fdC, fdP, urC, urP;
    play_enable = 1'b1;
    while (modelQ.size() > 0) begin
      modelStart(play_enable, 1'b0, '0, '0, expL, expR, expUr);
      runSlot(1'b0, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsL, fdC, fdP, urC, urP);
      runSlot(1'b1, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsR, fdC, fdP, urC, urP);
    end
    applyStimulus(DATA_W'($urandom), {DATA_W{1'b1}});
    applyStimulus(DATA_W'($urandom), DATA_W'($urandom));
    modelStart(play_enable, 1'b0, '0, '0, expL, expR, expUr);
    runSlot(1'b0, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsL, fdC, fdP, urC, urP);
    runSlot(1'b1, 11, 1'b0, '0, '0, -1, 1'b0, bitsR, fdC, fdP, urC, urP);
    testsRun++;
    if (bitsR[SLOT_W-1 -: 11] !== expR[DATA_W-1 -: 11]) begin testsFailed++; $display("[TB] FAIL rstmid_before: got %h, expected %h", bitsR[SLOT_W-1 -: 11], expR[DATA_W-1 -: 11]); end
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (aud_dacdat !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_dacdat: got %b, expected 0", aud_dacdat); end
    testsRun++;
    if (fifo_level !== '0 || wr_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid_fifo: got level %0d ready %b, expected 0 1", fifo_level, wr_ready); end
    toNeg();
    rst_n = 1'b1;
    modelQ.delete();
    runSlot(1'b1, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsR, fdC, fdP, urC, urP);
    testsRun++;
    if (bitsR !== '0) begin testsFailed++; $display("[TB] FAIL rstmid_silent_after: got %h, expected 0", bitsR); end
    applyStimulus(DATA_W'($urandom), DATA_W'($urandom));
    modelStart(play_enable, 1'b0, '0, '0, expL, expR, expUr);
    runSlot(1'b0, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsL, fdC, fdP, urC, urP);
    runSlot(1'b1, SLOT_W, 1'b0, '0, '0, -1, 1'b0, bitsR, fdC, fdP, urC, urP);
    testsRun++;
    if (bitsL !== slotWord(expL) || bitsR !== slotWord(expR)) begin testsFailed++; $display("[TB] FAIL rstmid_first_frame: got %h/%h, expected %h/%h", bitsL, bitsR, slotWord(expL), slotWord(expR)); end
  endtask

  // Run every scenario in order and report.
  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_full();
    test_pe_drop();
    test_back_to_back();
    test_early_toggle();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/audio_tx_stereo.md
AUDIO_TX_STEREO -- requirements
Module: audio_tx_stereo

Parameters
REQ-001 The block SHALL provide parameter DATA_W, default 24, meaning sample width in bits per channel (legal 16..32).
REQ-002 The block SHALL provide parameter SLOT_W, default 32, meaning BCLK cycles per LRC half-period (legal DATA_W..63).
REQ-003 The block SHALL provide parameter FIFO_DEPTH, default 4, meaning stereo frames buffered (power of 2, at least 2).

Interface
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 aud_bclk  input  1  clock; all logic on posedge, except aud_dacdat on negedge.
REQ-006 aud_lrc  input  1  word select: 0 = left slot, 1 = right slot.
REQ-007 play_enable  input  1  playback enable, sampled only at frame start.
REQ-008 wr_valid  input  1  write request for one stereo frame.
REQ-009 wr_ready  output  1  equals !fifo_full, combinational.
REQ-010 wr_left  input  DATA_W  left sample.
REQ-011 wr_right  input  DATA_W  right sample.
REQ-012 aud_dacdat  output  1  serial data, MSB first.
REQ-013 fifo_level  output  clog2(FIFO_DEPTH+1)  frames stored.
REQ-014 frame_done  output  1  one-cycle pulse: right-channel data bits finished.
REQ-015 underrun  output  1  one-cycle pulse: frame start with FIFO empty while enabled.

Function
REQ-016 lrc_d0 SHALL register aud_lrc on posedge; lrc_edge SHALL be aud_lrc XOR lrc_d0; current channel SHALL be lrc_d0.
REQ-017 Push: wr_valid && wr_ready SHALL write {wr_left, wr_right} at the write pointer and increment it, with wrap modulo FIFO_DEPTH.
REQ-018 Frame start SHALL be a posedge with lrc_edge=1 and aud_lrc=0.
REQ-019 At frame start with play_enable=1 and FIFO non-empty, the block SHALL pop one frame into the left and right hold registers.
REQ-020 At frame start with play_enable=1 and FIFO empty, the block SHALL load zeros into both hold registers and pulse underrun on the next cycle.
REQ-021 At frame start with play_enable=0, the block SHALL load zeros into both hold registers, SHALL NOT pop, and SHALL NOT pulse underrun.
REQ-022 Push and pop in the same cycle SHALL leave fifo_level unchanged; push to an empty FIFO in the pop cycle SHALL still underrun, and the pushed frame SHALL be stored.
REQ-023 fifo_level SHALL track pushes minus pops exactly, range 0..FIFO_DEPTH.
REQ-024 bit_cnt (6 bits) SHALL clear on any lrc_edge, otherwise increment and saturate at SLOT_W.
REQ-025 On negedge, aud_dacdat SHALL be hold[channel][DATA_W-1-bit_cnt] when bit_cnt < DATA_W, else 0.
REQ-026 The MSB SHALL appear on the first negedge after the edge-detect posedge (I2S one-bit delay).
REQ-027 Bits DATA_W..SLOT_W-1 of each slot SHALL be 0.
REQ-028 frame_done SHALL assert for one cycle on the posedge after bit_cnt==DATA_W with lrc_d0=1, every frame, including muted or underrun frames.
REQ-029 If LRC toggles early (bit_cnt < DATA_W), the new slot SHALL start cleanly and the truncated slot's remaining bits SHALL be dropped.
REQ-030 play_enable changes mid-frame SHALL NOT affect the frame in progress.

Reset
REQ-031 rst_n low SHALL immediately clear aud_dacdat, underrun, frame_done, lrc_d0, bit_cnt, the hold registers, and both FIFO pointers; fifo_level SHALL read 0 and wr_ready 1.
REQ-032 After release, no data SHALL be output before the first frame start; if aud_lrc=1 at release, the first slot SHALL be treated as right and output zeros.
REQ-033 FIFO contents need no reset.

Verification (DATA_W=24, SLOT_W=32, FIFO_DEPTH=4)
REQ-034 Push L=0xA5A5A5, R=0x5A5A5A with play_enable=1, then LRC fall -> left slot serialises 101001011010010110100101 followed by 8 zeros; right slot serialises 0x5A5A5A; frame_done pulses once; fifo_level 1->0.
REQ-035 FIFO empty, play_enable=1, LRC fall -> underrun pulses for exactly 1 cycle; aud_dacdat is 0 for the whole frame; frame_done still pulses.
REQ-036 Five back-to-back pushes, no LRC edge -> wr_ready=0 after the 4th; fifo_level=4; 5th frame dropped; drain order equals push order.
REQ-037 play_enable dropped at left bit_cnt=5 -> current frame completes with full data; next frame all zeros; fifo_level unchanged; no underrun.
REQ-038 fifo_level=1, push and frame start in the same cycle -> level stays 1; the popped frame is the older one.
REQ-039 rst_n low at right-slot bit_cnt=10 -> aud_dacdat=0 at once; fifo_level=0; after release, output stays 0 until the first LRC fall with data pushed.
